// File: rtl/ser_des_link.sv
// ser_des_link: single-lane serializer/deserializer.
// Frame: start(0) / data LSB-first / optional even parity / stop(1).
// Ports:
//   clk, reset           - clock (rising edge), asynchronous active-high reset
//   in_data/in_valid     - parallel word to transmit; in_ready = TX idle
//   ser_out              - serial TX line, idles high
//   ser_in               - asynchronous serial RX line (2-FF synchronised)
//   loopback             - 1: RX listens to ser_out; 0: RX listens to ser_in
//   out_data/out_valid   - last good received word and its 1-clk strobe
//   frame_err/parity_err - 1-clk strobes for bad stop bit / parity mismatch
module ser_des_link #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned PARITY_EN    = 1,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_out,
    input  logic              ser_in,
    input  logic              loopback,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              frame_err,
    output logic              parity_err
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t              r_tx_state;
    logic [CNT_W-1:0]    r_tx_cnt;
    logic [BIT_W-1:0]    r_tx_bit;
    logic [DATA_W-1:0]   r_tx_shift;
    logic                r_tx_par;
    logic                r_ser_out;
    logic [DATA_W-1:0]   w_tx_next;
    logic                w_tx_bit_done;

    state_t              r_rx_state;
    logic [CNT_W-1:0]    r_rx_cnt;
    logic [BIT_W-1:0]    r_rx_bit;
    logic [DATA_W-1:0]   r_rx_shift;
    logic                r_rx_par;
    logic [1:0]          r_sync;
    logic                w_rx_line;
    logic                w_rx_bit_done;
    logic [DATA_W-1:0]   w_rx_shift_in;

    assign in_ready      = (r_tx_state == S_IDLE);
    assign ser_out       = r_ser_out;
    assign w_tx_next     = r_tx_shift >> 1;
    assign w_tx_bit_done = (r_tx_cnt == LAST_CNT);

    // TX: the line value for the next bit is registered at each bit boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_ser_out  <= 1'b1;
        end else begin
            case (r_tx_state)
                S_IDLE: begin
                    r_ser_out <= 1'b1;
                    if (in_valid) begin
                        r_tx_shift <= in_data;
                        r_tx_par   <= ^in_data;
                        r_tx_cnt   <= '0;
                        r_ser_out  <= 1'b0;
                        r_tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tx_bit_done) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_ser_out  <= r_tx_shift[0];
                        r_tx_state <= S_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_tx_bit_done) begin
                        r_tx_cnt   <= '0;
                        r_tx_shift <= w_tx_next;
                        if (r_tx_bit == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                r_ser_out  <= r_tx_par;
                                r_tx_state <= S_PARITY;
                            end else begin
                                r_ser_out  <= 1'b1;
                                r_tx_state <= S_STOP;
                            end
                        end else begin
                            r_tx_bit  <= r_tx_bit + BIT_W'(1);
                            r_ser_out <= w_tx_next[0];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    if (w_tx_bit_done) begin
                        r_tx_cnt   <= '0;
                        r_ser_out  <= 1'b1;
                        r_tx_state <= S_STOP;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_tx_bit_done) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= S_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                    end
                end
                default: r_tx_state <= S_IDLE;
            endcase
        end
    end

    // Two-flop synchroniser for the external line; idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_sync <= 2'b11;
        else       r_sync <= {r_sync[0], ser_in};
    end

    assign w_rx_line     = loopback ? r_ser_out : r_sync[1];
    assign w_rx_bit_done = (r_rx_cnt == LAST_CNT);
    assign w_rx_shift_in = (r_rx_shift >> 1) | (DATA_W'(w_rx_line) << (DATA_W - 1));

    // RX: start re-checked at half-bit, then one sample per bit period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_par   <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            case (r_rx_state)
                S_IDLE: begin
                    if (!w_rx_line) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_rx_cnt == HALF_CNT) begin
                        r_rx_cnt <= '0;
                        if (w_rx_line) begin
                            r_rx_state <= S_IDLE;   // glitch, not a real start bit
                        end else begin
                            r_rx_bit   <= '0;
                            r_rx_par   <= 1'b0;
                            r_rx_state <= S_DATA;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_rx_bit_done) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= w_rx_shift_in;
                        r_rx_par   <= r_rx_par ^ w_rx_line;
                        if (r_rx_bit == LAST_BIT) begin
                            r_rx_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + BIT_W'(1);
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    if (w_rx_bit_done) begin
                        r_rx_cnt   <= '0;
                        r_rx_par   <= r_rx_par ^ w_rx_line;   // nonzero = mismatch
                        r_rx_state <= S_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_rx_bit_done) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= S_IDLE;
                        if (!w_rx_line) begin
                            frame_err <= 1'b1;
                        end else if ((PARITY_EN != 0) && r_rx_par) begin
                            parity_err <= 1'b1;
                        end else begin
                            out_data  <= r_rx_shift;
                            out_valid <= 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                default: r_rx_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ser_des_link.sv
// Directed bench for ser_des_link (DATA_W=8, PARITY_EN=1, CLKS_PER_BIT=4).
module tb_ser_des_link;

    localparam int unsigned DW  = 8;
    localparam int unsigned CPB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          ser_out;
    logic          ser_in;
    logic          loopback;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          frame_err;
    logic          parity_err;

    ser_des_link #(.DATA_W(DW), .PARITY_EN(1), .CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ser_out   (ser_out),
        .ser_in    (ser_in),
        .loopback  (loopback),
        .out_data  (out_data),
        .out_valid (out_valid),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_perr  = 0;
    int n_ferr  = 0;

    // Pulse counters sampled on the falling edge.
    always @(negedge clk) begin
        if (out_valid)  n_valid = n_valid + 1;
        if (parity_err) n_perr  = n_perr + 1;
        if (frame_err)  n_ferr  = n_ferr + 1;
    end

    typedef struct {
        logic          lb;
        logic [DW-1:0] data;
        logic          flip_par;
        logic          stop_bit;
        int            exp_valid;
        int            exp_perr;
        int            exp_ferr;
        logic [DW-1:0] exp_out;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        ser_in = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Frame on ser_in; called at a falling edge.
    task automatic send_ser(input logic [DW-1:0] d, input logic flip, input logic stop);
        drive_bit(1'b0);
        for (int b = 0; b < int'(DW); b++) drive_bit(d[b]);
        drive_bit((^d) ^ flip);
        drive_bit(stop);
        ser_in = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // Word through TX, bounded wait for in_ready; called at a falling edge.
    task automatic send_tx(input logic [DW-1:0] d);
        int waited;
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("tx_ready_wait", 32'(in_ready), 32'd1);
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~d;
        repeat (50) @(negedge clk);
    endtask

    vec_t          vecs[9];
    int            s_valid, s_perr, s_ferr;
    logic [10:0]   exp_bits;
    int            first_valid;
    logic [DW-1:0] words[3];
    logic [DW-1:0] rx_words[3];
    int            acc[3];
    int            idx, nrx, nerr;

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1, 0, 0, 8'hA5};
        vecs[1] = '{1'b0, 8'h33, 1'b0, 1'b1, 1, 0, 0, 8'h33};
        vecs[2] = '{1'b0, 8'h5A, 1'b1, 1'b1, 0, 1, 0, 8'h33};
        vecs[3] = '{1'b0, 8'h81, 1'b0, 1'b0, 0, 0, 1, 8'h33};
        vecs[4] = '{1'b0, 8'h81, 1'b0, 1'b1, 1, 0, 0, 8'h81};
        vecs[5] = '{1'b1, 8'h00, 1'b0, 1'b1, 1, 0, 0, 8'h00};
        vecs[6] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1, 0, 0, 8'hFF};
        vecs[7] = '{1'b0, 8'h01, 1'b0, 1'b1, 1, 0, 0, 8'h01};
        vecs[8] = '{1'b0, 8'h7E, 1'b1, 1'b0, 0, 0, 1, 8'h01};

        reset    = 1'b1;
        ser_in   = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        loopback = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ser_out",    32'(ser_out),    32'd1);
        check("rst_in_ready",   32'(in_ready),   32'd1);
        check("rst_out_data",   32'(out_data),   32'd0);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_frame_err",  32'(frame_err),  32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Exact line waveform and RX latency for 0xA5 in loopback.
        exp_bits = 11'b1_0_10100101_0;
        first_valid = -1;
        check("t1_ready", 32'(in_ready), 32'd1);
        in_data  = 8'hA5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int j = 0; j < 48; j++) begin
            if ((j % 4) == 1 && (j / 4) < 11)
                check($sformatf("t1_bit%0d", j / 4), 32'(ser_out), 32'(exp_bits[j / 4]));
            if (j == 5) check("t1_busy", 32'(in_ready), 32'd0);
            if (out_valid && first_valid < 0) first_valid = j;
            @(negedge clk);
        end
        check("t1_valid_seen", 32'(first_valid >= 0), 32'd1);
        check("t1_out_data", 32'(out_data), 32'hA5);
        repeat (5) @(negedge clk);

        // Table: loopback words and external frames with injected faults.
        foreach (vecs[i]) begin
            loopback = vecs[i].lb;
            s_valid = n_valid; s_perr = n_perr; s_ferr = n_ferr;
            if (vecs[i].lb) send_tx(vecs[i].data);
            else            send_ser(vecs[i].data, vecs[i].flip_par, vecs[i].stop_bit);
            check($sformatf("row%0d_valid", i), 32'(n_valid - s_valid), 32'(vecs[i].exp_valid));
            check($sformatf("row%0d_perr", i),  32'(n_perr - s_perr),   32'(vecs[i].exp_perr));
            check($sformatf("row%0d_ferr", i),  32'(n_ferr - s_ferr),   32'(vecs[i].exp_ferr));
            check($sformatf("row%0d_data", i),  32'(out_data),          32'(vecs[i].exp_out));
        end

        // Back-to-back words with in_valid held high.
        loopback = 1'b1;
        words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h3C;
        idx = 0; nrx = 0; nerr = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (idx < 3) in_data = words[idx];
            else         in_valid = 1'b0;
            if (idx < 3 && in_ready) begin
                acc[idx] = c;
                idx++;
            end
            if (out_valid) begin
                if (nrx < 3) rx_words[nrx] = out_data;
                nrx++;
            end
            if (frame_err || parity_err) nerr++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("t2_accepted", 32'(idx), 32'd3);
        if (idx == 3) begin
            check("t2_gap01", 32'(acc[1] - acc[0]), 32'd45);
            check("t2_gap12", 32'(acc[2] - acc[1]), 32'd45);
        end
        check("t2_nrx", 32'(nrx), 32'd3);
        for (int k = 0; k < 3; k++)
            if (k < nrx) check($sformatf("t2_word%0d", k), 32'(rx_words[k]), 32'(words[k]));
        check("t2_errs", 32'(nerr), 32'd0);

        // One-clock glitch on ser_in, then a clean frame.
        loopback = 1'b0;
        repeat (4) @(negedge clk);
        s_valid = n_valid; s_perr = n_perr; s_ferr = n_ferr;
        ser_in = 1'b0;
        @(negedge clk);
        ser_in = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_valid", 32'(n_valid - s_valid), 32'd0);
        check("t5_perr",  32'(n_perr - s_perr),   32'd0);
        check("t5_ferr",  32'(n_ferr - s_ferr),   32'd0);
        send_ser(8'hC3, 1'b0, 1'b1);
        check("t5_after_valid", 32'(n_valid - s_valid), 32'd1);
        check("t5_after_data",  32'(out_data),          32'hC3);

        // Reset in the middle of a TX data bit.
        loopback = 1'b1;
        in_data  = 8'h3C;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (11) @(negedge clk);
        check("t6_pre_ser_out", 32'(ser_out),  32'd0);
        check("t6_pre_ready",   32'(in_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("t6_ser_out",    32'(ser_out),    32'd1);
        check("t6_ready",      32'(in_ready),   32'd1);
        check("t6_out_valid",  32'(out_valid),  32'd0);
        check("t6_frame_err",  32'(frame_err),  32'd0);
        check("t6_parity_err", 32'(parity_err), 32'd0);
        check("t6_out_data",   32'(out_data),   32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        s_valid = n_valid; s_perr = n_perr; s_ferr = n_ferr;
        send_tx(8'h96);
        check("t6_post_valid", 32'(n_valid - s_valid), 32'd1);
        check("t6_post_data",  32'(out_data),          32'h96);
        check("t6_post_errs",  32'((n_perr - s_perr) + (n_ferr - s_ferr)), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
